// File: rtl/keypad_emul_if.sv
// Key-request channel between a sequence player (master) and the keypad emulator (slave).
// A request transfers on every rising clock edge where req_valid and req_ready are both high.
// The master holds req_valid, scan_sel and ret_sel stable until that edge.
interface keypad_emul_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] scan_sel;
  logic [2:0] ret_sel;

  modport master (output req_valid, output scan_sel, output ret_sel, input req_ready);
  modport slave  (input req_valid, input scan_sel, input ret_sel, output req_ready);
endinterface

// File: rtl/keypad_emul.sv
// Responder end of a 4-scan x 5-return keypad matrix: presses one key with bounce,
// holds it for a number of scans, releases it, then reports done (or err on abort).
module keypad_emul #(
  parameter int P_HOLD_SCANS = 20,
  parameter int P_GAP_SCANS  = 20,
  parameter int P_BOUNCE_TGL = 4,
  parameter int P_BOUNCE_PER = 1000,
  parameter int P_TIMEOUT    = 2_000_000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  keypad_emul_if.slave       req_if,
  input  logic [3:0]         i_key_scan,
  output logic [4:0]         o_key_ret,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [2:0]         o_dbg_state
);

  localparam int LP_EDGE_MAX = (P_HOLD_SCANS > P_GAP_SCANS) ? P_HOLD_SCANS : P_GAP_SCANS;
  localparam int LP_EDGE_W   = $clog2(LP_EDGE_MAX + 1);
  localparam int LP_TMO_W    = $clog2(P_TIMEOUT + 1);
  localparam int LP_BPER_W   = $clog2(P_BOUNCE_PER + 1);
  localparam int LP_TGL_W    = (P_BOUNCE_TGL > 0) ? $clog2(P_BOUNCE_TGL + 1) : 1;

  localparam logic [LP_EDGE_W-1:0] LP_HOLD_LAST = LP_EDGE_W'(P_HOLD_SCANS - 1);
  localparam logic [LP_EDGE_W-1:0] LP_GAP_LAST  = LP_EDGE_W'(P_GAP_SCANS - 1);
  localparam logic [LP_TMO_W-1:0]  LP_TMO_LAST  = LP_TMO_W'(P_TIMEOUT - 1);
  localparam logic [LP_BPER_W-1:0] LP_BPER_LAST = LP_BPER_W'(P_BOUNCE_PER - 1);
  localparam logic [LP_TGL_W-1:0]  LP_TGL_LAST  = LP_TGL_W'(P_BOUNCE_TGL - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BOUNCE = 3'd1,
    S_HOLD   = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_pressed;
  logic [1:0]            r_sel_scan;
  logic [2:0]            r_sel_ret;
  logic                  r_scan_q;
  logic [LP_TMO_W-1:0]   r_tmo_cnt;
  logic [LP_EDGE_W-1:0]  r_edge_cnt;
  logic [LP_BPER_W-1:0]  r_bper_cnt;
  logic [LP_TGL_W-1:0]   r_tgl_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic                  w_sel_line;
  logic                  w_edge;
  logic                  w_timeout;
  logic [4:0]            w_key_ret;

  assign w_sel_line = i_key_scan[r_sel_scan];
  assign w_edge     = r_scan_q & ~w_sel_line;
  // A falling edge proves the scanner is alive, so it always beats a coincident timeout.
  assign w_timeout  = (r_tmo_cnt == LP_TMO_LAST) & ~w_edge;

  // Return line follows the live scan line so the key only shows in its own scan slot.
  always_comb begin
    w_key_ret = 5'b11111;
    for (int b = 0; b < 5; b++) begin
      if (r_sel_ret == 3'(b)) w_key_ret[b] = ~(r_pressed & ~w_sel_line);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pressed  <= 1'b0;
      r_sel_scan <= 2'd0;
      r_sel_ret  <= 3'd0;
      r_scan_q   <= 1'b1;
      r_tmo_cnt  <= '0;
      r_edge_cnt <= '0;
      r_bper_cnt <= '0;
      r_tgl_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_scan_q <= w_sel_line;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_if.req_valid) begin
            r_sel_scan <= req_if.scan_sel;
            r_sel_ret  <= req_if.ret_sel;
            // Prime the edge detector on the new line so acceptance never counts as an edge.
            r_scan_q   <= i_key_scan[req_if.scan_sel];
            r_busy     <= 1'b1;
            r_tmo_cnt  <= '0;
            r_edge_cnt <= '0;
            r_bper_cnt <= '0;
            r_tgl_cnt  <= '0;
            if (req_if.ret_sel > 3'd4) begin
              r_state <= S_ERR;
            end else begin
              r_pressed <= 1'b1;
              r_state   <= (P_BOUNCE_TGL == 0) ? S_HOLD : S_BOUNCE;
            end
          end
        end
        S_BOUNCE: begin
          if (w_timeout) begin
            r_pressed <= 1'b0;
            r_state   <= S_ERR;
          end else begin
            r_tmo_cnt <= w_edge ? '0 : r_tmo_cnt + 1'b1;
            if (r_bper_cnt == LP_BPER_LAST) begin
              r_bper_cnt <= '0;
              if (r_tgl_cnt == LP_TGL_LAST) begin
                r_pressed  <= 1'b1;
                r_tmo_cnt  <= '0;
                r_edge_cnt <= '0;
                r_state    <= S_HOLD;
              end else begin
                r_pressed <= ~r_pressed;
                r_tgl_cnt <= r_tgl_cnt + 1'b1;
              end
            end else begin
              r_bper_cnt <= r_bper_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_edge) begin
            r_tmo_cnt <= '0;
            if (r_edge_cnt == LP_HOLD_LAST) begin
              r_pressed  <= 1'b0;
              r_edge_cnt <= '0;
              r_state    <= S_GAP;
            end else begin
              r_edge_cnt <= r_edge_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            r_pressed <= 1'b0;
            r_state   <= S_ERR;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (w_edge) begin
            r_tmo_cnt <= '0;
            if (r_edge_cnt == LP_GAP_LAST) begin
              r_edge_cnt <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_edge_cnt <= r_edge_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            r_pressed <= 1'b0;
            r_state   <= S_ERR;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_tmo_cnt <= '0;
          r_state   <= S_IDLE;
        end
        // o_done shows during DONE itself; o_err shows on the cycle after ERR.
        S_ERR: begin
          r_tmo_cnt <= '0;
          r_busy    <= 1'b0;
          r_err     <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_if.req_ready = (r_state == S_IDLE);
  assign o_key_ret        = w_key_ret;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_err            = r_err;
  assign o_dbg_state      = r_state;

endmodule
